// File: rtl/regfile_dump.sv
// regfile_dump: sequential read-out engine for the register file.
//
// On start (sampled in IDLE) the core is halted, the register file read
// port is walked from index 0 to NUM_REGS-1, and each value is streamed
// out on a valid/ready channel. Each register takes a FETCH cycle, which
// captures the combinational read data, followed by a SEND cycle, which
// holds the beat until it is accepted.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   defined   - one extra beat (CSUM) carries the XOR of all dumped values.
//               That beat has out_csum=1, out_last=1 and out_index=0.
//   undefined - no accumulator and no CSUM state. out_csum is tied 0 and
//               out_last marks the final data beat.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start           dump request (sampled only in IDLE)
//   rd_data         combinational register file data for rd_addr
//   rd_addr         register index presented to the register file
//   halt_req        core stall request (registered; high outside IDLE)
//   out_valid/out_ready/out_data/out_index/out_last/out_csum  beat channel
//   done            one-cycle pulse after the final beat is accepted
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              halt_req,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_csum,
  output logic              done
);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] index;
  logic              accept;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  assign accept = out_valid & out_ready;

  // next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = FETCH;
      FETCH:   nxt = SEND;
      SEND: begin
        if (out_ready) begin
          if (index != LAST_IDX) nxt = FETCH;
`ifdef REGDUMP_CHECKSUM_EN
          else                   nxt = CSUM;
`else
          else                   nxt = DONE;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM:    if (out_ready) nxt = DONE;
`endif
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs decoded from state; all are 0 in IDLE and while in reset
  always_comb begin
    rd_addr   = index;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_csum  = 1'b0;
    done      = 1'b0;
    case (state)
      SEND: begin
        out_valid = 1'b1;
`ifndef REGDUMP_CHECKSUM_EN
        out_last  = (index == LAST_IDX);
`endif
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_csum  = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      index     <= '0;
      halt_req  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      state    <= nxt;
      // registered from next state: rises the cycle after start is taken,
      // stays up through DONE
      halt_req <= (nxt != IDLE);
      case (state)
        IDLE: begin
          index <= '0;
`ifdef REGDUMP_CHECKSUM_EN
          if (start) acc <= '0;
`endif
        end
        FETCH: begin
          out_data  <= rd_data;
          out_index <= index;
`ifdef REGDUMP_CHECKSUM_EN
          acc       <= acc ^ rd_data;
`endif
        end
        SEND: begin
          if (accept) begin
            if (index != LAST_IDX) begin
              index <= index + 1'b1;
            end else begin
`ifdef REGDUMP_CHECKSUM_EN
              // payload registers are reused for the checksum beat
              out_data  <= acc;
              out_index <= '0;
`endif
            end
          end
        end
        DONE:    index <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: table of dump scenarios checked beat-by-beat
// against a queue of expected beats derived from the register file
// contents, plus hand sequences for async reset and back-to-back dumps.
module tb_regfile_dump;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int NBEATS   = N + (CS ? 1 : 0);
  localparam int DUMP_LEN = 2 * N + (CS ? 1 : 0);

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr, out_index;
  logic          halt_req, out_valid, out_last, out_csum, done;
  logic [DW-1:0] out_data;
  logic [DW-1:0] rf [N];

  regfile_dump #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_data(rd_data), .out_ready(out_ready),
    .rd_addr(rd_addr), .halt_req(halt_req), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_csum(out_csum), .done(done)
  );

  always_comb rd_data = rf[rd_addr];
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct { logic [DW-1:0] d; logic [AW-1:0] i; logic last; logic cs; } beat_t;
  beat_t exp_q[$];

  typedef struct {
    int kind; int stall_idx; int stall_len; bit rnd; int mid_start;
    bit xor_model; logic [DW-1:0] exp_xor;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic load(input int kind);
    for (int i = 0; i < N; i++)
      case (kind)
        0:       rf[i] = 32'h1 << i;
        1:       rf[i] = $urandom;
        2:       rf[i] = '0;
        default: rf[i] = 32'hA5A5_A5A5;
      endcase
  endtask

  // expected beat stream: every register in order, then the checksum beat
  function automatic logic [DW-1:0] build_exp();
    logic [DW-1:0] x = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back('{rf[i], AW'(i), (!CS && i == N - 1), 1'b0});
      x ^= rf[i];
    end
    if (CS) exp_q.push_back('{x, '0, 1'b1, 1'b1});
    return x;
  endfunction

  // Called on the negedge of the first cycle after start was sampled.
  // Returns on the negedge where done is seen, or where an abort index
  // is on the channel.
  task automatic monitor(input int stall_idx, input int stall_len, input bit rnd,
                         input int mid_idx, input int abort_idx,
                         output int nb, output logic [DW-1:0] xr, output bit aborted);
    int cyc, stalled;
    bit prev, halt_bad, mid_fired, fin, rdy;
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    beat_t e;
    cyc = 0; stalled = 0; prev = 0; halt_bad = 0; mid_fired = 0; fin = 0;
    nb = 0; xr = '0; aborted = 0; pd = '0; pi = '0;
    while (!fin) begin
      if (halt_req !== 1'b1) halt_bad = 1'b1;
      if (done === 1'b1) begin
        chk("done_after_last_beat", exp_q.size(), 0);
        if (!rnd) chk("dump_cycles", cyc, DUMP_LEN + stalled);
        fin = 1;
      end else if (cyc > 4000) begin
        chk("timeout_cycles", cyc, 0);
        fin = 1;
      end else begin
        if (prev) chk("stall_hold", {out_valid, out_index, out_data}, {1'b1, pi, pd});
        prev = 0;
        if (out_valid && !out_csum && int'(out_index) == abort_idx) begin
          aborted = 1; fin = 1;
        end else begin
          if (out_valid && !out_csum && int'(out_index) == stall_idx && stalled < stall_len) begin
            rdy = 1'b0;
            // corrupt the source so a payload that is not held would show it
            if (stalled == 0) rf[stall_idx] ^= 32'hDEAD_BEEF;
            stalled++;
          end else begin
            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
          out_ready = rdy;
          if (out_valid && rdy) begin
            if (exp_q.size() == 0) chk("extra_beat", nb, NBEATS);
            else begin
              e = exp_q.pop_front();
              chk($sformatf("beat%0d", nb), {out_csum, out_last, out_index, out_data},
                  {e.cs, e.last, e.i, e.d});
            end
            nb++;
            if (!out_csum) xr ^= out_data;
          end else if (out_valid) begin
            prev = 1; pd = out_data; pi = out_index;
          end
          if (mid_fired && start) start = 1'b0;
          if (out_valid && int'(out_index) == mid_idx && !mid_fired) begin
            start = 1'b1; mid_fired = 1;
          end
          @(negedge clk);
          cyc++;
        end
      end
    end
    chk("halt_held_during_dump", halt_bad, 0);
  endtask

  task automatic idle_chk(input string name);
    chk(name, {done, out_valid, halt_req, out_last, out_csum, rd_addr}, '0);
  endtask

  task automatic run_dump(input vec_t v);
    logic [DW-1:0] x, xr;
    int nb;
    bit ab;
    load(v.kind);
    x = build_exp();
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    monitor(v.stall_idx, v.stall_len, v.rnd, v.mid_start, -1, nb, xr, ab);
    chk("beat_count", nb, NBEATS);
    chk("data_xor", xr, v.xor_model ? x : v.exp_xor);
    @(negedge clk); idle_chk("idle_after_done");
  endtask

  initial begin
    logic [DW-1:0] xr;
    int nb;
    bit ab;
    vecs[0] = '{0, -1, 0, 1'b0, 3,  1'b0, 32'hFFFF_FFFF};  // basic + ignored mid start
    vecs[1] = '{0,  7, 5, 1'b0, -1, 1'b0, 32'hFFFF_FFFF};  // backpressure on r7
    vecs[2] = '{2, -1, 0, 1'b1, -1, 1'b0, 32'h0};          // zeros, random ready
    vecs[3] = '{3, 31, 3, 1'b0, 20, 1'b0, 32'h0};          // constant, stall last
    vecs[4] = '{1,  0, 2, 1'b1, -1, 1'b1, 32'h0};          // random data/ready

    load(0);
    #1;
    chk("reset_outputs", {rd_addr, halt_req, out_valid, out_data, out_index,
                          out_last, out_csum, done}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); idle_chk("idle_after_reset");

    for (int k = 0; k < 5; k++) run_dump(vecs[k]);

    // async reset in the middle of a dump
    load(0); void'(build_exp());
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    monitor(-1, 0, 1'b0, -1, 12, nb, xr, ab);
    chk("reached_abort_index", ab, 1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {rd_addr, halt_req, out_valid, out_data, out_index,
                                   out_last, out_csum, done}, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("no_done_in_reset", {done, out_valid, halt_req}, '0);
    end
    #2 rst = 1'b1;
    run_dump(vecs[0]);

    // back-to-back with start held high
    load(0); void'(build_exp());
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk);
    monitor(-1, 0, 1'b0, -1, -1, nb, xr, ab);
    chk("b2b_first_count", nb, NBEATS);
    @(negedge clk); idle_chk("b2b_idle_gap");
    void'(build_exp());
    @(posedge clk); @(negedge clk); start = 1'b0;
    monitor(-1, 0, 1'b0, -1, -1, nb, xr, ab);
    chk("b2b_second_count", nb, NBEATS);
    @(negedge clk); idle_chk("b2b_idle_end");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
